// File: rtl/debouncer_multi.sv
// -----------------------------------------------------------------------------
// debouncer_multi
//
// N-channel push-button conditioner. Each channel has a two-flop synchroniser,
// polarity normalisation, a counter-based debounce, one-cycle press/release
// event pulses and optional hold-to-repeat pulses.
//
// Ports:
//   clk            rising-edge clock for all logic
//   rst_n          asynchronous active-low reset
//   btn_in         raw asynchronous pin levels, one bit per channel
//   evt_mask       1 suppresses press/release/repeat pulses of that channel
//   btn_level      debounced, normalised level (1 = pressed)
//   press_pulse    one-cycle pulse after a press is accepted
//   release_pulse  one-cycle pulse after a release is accepted
//   repeat_pulse   one-cycle auto-repeat pulse while held (0 if REPEAT_EN=0)
//   any_pressed    registered OR of btn_level
//
// There are no handshakes: every output is a plain registered level or pulse.
// -----------------------------------------------------------------------------
module debouncer_multi #(
    parameter int N_CH            = 4,
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int ACTIVE_LOW      = 1,
    parameter int REPEAT_EN       = 0,
    parameter int REPEAT_DELAY    = 25_000_000,
    parameter int REPEAT_PERIOD   = 5_000_000
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N_CH-1:0] btn_in,
    input  logic [N_CH-1:0] evt_mask,
    output logic [N_CH-1:0] btn_level,
    output logic [N_CH-1:0] press_pulse,
    output logic [N_CH-1:0] release_pulse,
    output logic [N_CH-1:0] repeat_pulse,
    output logic            any_pressed
);

    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);

    // Raw pin level that means "not pressed"; the synchroniser resets to it so
    // that leaving reset never looks like a pin change.
    localparam logic [N_CH-1:0] IDLE_RAW = (ACTIVE_LOW != 0) ? {N_CH{1'b1}} : {N_CH{1'b0}};

    logic [N_CH-1:0] s0;
    logic [N_CH-1:0] s1;
    logic [N_CH-1:0] pressed;
    logic [N_CH-1:0] level_d;
    logic [N_CH-1:0] rise;
    logic [N_CH-1:0] fall;
    logic [N_CH-1:0] accept;
    logic [DW-1:0]   db_cnt [N_CH];

    assign pressed = (ACTIVE_LOW != 0) ? ~s1 : s1;

    // level_d is btn_level one cycle late, so these are high exactly in the
    // cycle after the debounced level changed.
    assign rise = btn_level & ~level_d;
    assign fall = ~btn_level & level_d;

    // A channel accepts its new level on the last of DEBOUNCE_CYCLES
    // consecutive cycles in which the normalised pin disagrees with btn_level.
    always_comb begin
        accept = '0;
        for (int i = 0; i < N_CH; i++) begin
            accept[i] = (pressed[i] != btn_level[i]) && (db_cnt[i] == DB_LAST);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s0            <= IDLE_RAW;
            s1            <= IDLE_RAW;
            btn_level     <= '0;
            level_d       <= '0;
            press_pulse   <= '0;
            release_pulse <= '0;
            any_pressed   <= 1'b0;
            for (int i = 0; i < N_CH; i++) begin
                db_cnt[i] <= '0;
            end
        end else begin
            s0            <= btn_in;
            s1            <= s0;
            level_d       <= btn_level;
            any_pressed   <= |btn_level;
            press_pulse   <= rise & ~evt_mask;
            release_pulse <= fall & ~evt_mask;
            for (int i = 0; i < N_CH; i++) begin
                if (pressed[i] == btn_level[i]) begin
                    db_cnt[i] <= '0;
                end else if (accept[i]) begin
                    btn_level[i] <= pressed[i];
                    db_cnt[i]    <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + DW'(1);
                end
            end
        end
    end

    if (REPEAT_EN != 0) begin : g_repeat
        localparam int HW = $clog2(REPEAT_DELAY);
        localparam logic [HW-1:0] HOLD_LAST   = HW'(REPEAT_DELAY - 1);
        localparam logic [HW-1:0] HOLD_RELOAD = HW'(REPEAT_DELAY - REPEAT_PERIOD);

        logic [HW-1:0] hold_cnt [N_CH];

        // The hold counter starts from 0 in the cycle the level rises and
        // reloads on terminal count, so the first repeat comes REPEAT_DELAY
        // cycles after the rise and the rest every REPEAT_PERIOD cycles.
        // A release accepted on a terminal-count cycle wins over the repeat.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                repeat_pulse <= '0;
                for (int i = 0; i < N_CH; i++) begin
                    hold_cnt[i] <= '0;
                end
            end else begin
                for (int i = 0; i < N_CH; i++) begin
                    repeat_pulse[i] <= btn_level[i] & ~rise[i] & ~accept[i]
                                       & ~evt_mask[i] & (hold_cnt[i] == HOLD_LAST);
                    if (!btn_level[i] || rise[i]) begin
                        hold_cnt[i] <= '0;
                    end else if (hold_cnt[i] == HOLD_LAST) begin
                        hold_cnt[i] <= HOLD_RELOAD;
                    end else begin
                        hold_cnt[i] <= hold_cnt[i] + HW'(1);
                    end
                end
            end
        end
    end else begin : g_no_repeat
        assign repeat_pulse = '0;
    end

endmodule

// File: tb/tb_debouncer_multi.sv
// -----------------------------------------------------------------------------
// tb_debouncer_multi
//
// Directed scenarios (clean press, bounce, hold/repeat, masking, reset,
// simultaneous press) with literal expectations, followed by randomized pin and
// mask activity. A behavioural model predicts every output each cycle from a
// history of sampled pin levels and the cycle number of each accepted press.
// -----------------------------------------------------------------------------
module tb_debouncer_multi;

    localparam int N_CH = 4;
    localparam int DB   = 4;
    localparam int RD   = 10;
    localparam int RP   = 3;

    logic            clk;
    logic            rst_n;
    logic [N_CH-1:0] btn_in;
    logic [N_CH-1:0] evt_mask;
    logic [N_CH-1:0] btn_level;
    logic [N_CH-1:0] press_pulse;
    logic [N_CH-1:0] release_pulse;
    logic [N_CH-1:0] repeat_pulse;
    logic            any_pressed;

    int checks = 0;
    int errors = 0;

    debouncer_multi #(
        .N_CH(N_CH), .DEBOUNCE_CYCLES(DB), .ACTIVE_LOW(1),
        .REPEAT_EN(1), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
    ) dut (
        .clk(clk), .rst_n(rst_n), .btn_in(btn_in), .evt_mask(evt_mask),
        .btn_level(btn_level), .press_pulse(press_pulse),
        .release_pulse(release_pulse), .repeat_pulse(repeat_pulse),
        .any_pressed(any_pressed)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- behavioural model + scoreboard ----------------
    // hist[ch][j] = normalised pin sampled j+1 edges ago (bit 0 = last edge).
    // The level flips once the D samples that reached the debouncer in the
    // last D cycles (hist bits D..1) all disagree with the current level.
    logic [DB:0]     hist [N_CH];
    logic [N_CH-1:0] m_lvl;
    logic [N_CH-1:0] m_prev;
    int              rise_at [N_CH];
    int              cyc;
    logic [16:0]     exp_q [$];

    always @(posedge clk) begin
        logic [N_CH-1:0] e_lvl, e_prs, e_rel, e_rep;
        logic            e_any;
        logic            flip;
        if (!rst_n) begin
            for (int c = 0; c < N_CH; c++) begin
                hist[c]    = '0;
                rise_at[c] = 0;
            end
            m_lvl  = '0;
            m_prev = '0;
            cyc    = 0;
            exp_q.push_back('0);
        end else begin
            cyc++;
            e_any = |m_lvl;
            for (int c = 0; c < N_CH; c++) begin
                flip = 1'b1;
                for (int j = 1; j <= DB; j++) begin
                    if (hist[c][j] == m_lvl[c]) flip = 1'b0;
                end
                e_lvl[c] = flip ? ~m_lvl[c] : m_lvl[c];
                e_prs[c] = m_lvl[c] & ~m_prev[c] & ~evt_mask[c];
                e_rel[c] = ~m_lvl[c] & m_prev[c] & ~evt_mask[c];
                e_rep[c] = m_lvl[c] & e_lvl[c] & ~evt_mask[c]
                           & (cyc >= rise_at[c] + 1 + RD)
                           & (((cyc - rise_at[c] - 1 - RD) % RP) == 0);
                if (e_lvl[c] && !m_lvl[c]) rise_at[c] = cyc;
                hist[c] = {hist[c][DB-1:0], ~btn_in[c]};
            end
            m_prev = m_lvl;
            m_lvl  = e_lvl;
            exp_q.push_back({e_lvl, e_prs, e_rel, e_rep, e_any});
        end
    end

    always @(posedge clk) begin
        logic [16:0] exp_w;
        logic [16:0] act_w;
        #1;
        act_w = {btn_level, press_pulse, release_pulse, repeat_pulse, any_pressed};
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL model_cycle: no expectation queued, outputs %h", act_w);
        end else begin
            exp_w = exp_q.pop_front();
            if (act_w !== exp_w) begin
                errors++;
                $display("FAIL model_cycle t=%0t: got lvl/prs/rel/rep/any %h/%h/%h/%h/%b expected %h/%h/%h/%h/%b",
                         $time, act_w[16:13], act_w[12:9], act_w[8:5], act_w[4:1], act_w[0],
                         exp_w[16:13], exp_w[12:9], exp_w[8:5], exp_w[4:1], exp_w[0]);
            end
        end
    end

    // ---------------- driver helpers ----------------
    // step(n): let n rising edges pass, then sit on the following falling edge.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    int rates [3] = '{2, 8, 40};

    // ---------------- stimulus ----------------
    initial begin
        int rate;
        logic saw;
        btn_in   = '1;
        evt_mask = '0;
        rst_n    = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_level", btn_level, 0);
        check("reset_pulses", {press_pulse, release_pulse, repeat_pulse}, 0);
        check("reset_any", any_pressed, 0);
        rst_n = 1'b1;
        step(8);
        check("idle_level", btn_level, 0);

        // clean press on channel 0: sampled by s0 at edge k
        btn_in[0] = 1'b0;
        step(5);
        check("press_level_k4", btn_level[0], 0);
        step(1);
        check("press_level_k5", btn_level[0], 1);
        check("press_pulse_k5", press_pulse[0], 0);
        check("press_any_k5", any_pressed, 0);
        step(1);
        check("press_pulse_k6", press_pulse[0], 1);
        check("press_any_k6", any_pressed, 1);
        step(1);
        check("press_pulse_k7", press_pulse[0], 0);

        // bounce on channel 1: runs of 3 never reach 4
        btn_in[1] = 1'b0; repeat (3) @(negedge clk);
        btn_in[1] = 1'b1; @(negedge clk);
        btn_in[1] = 1'b0; repeat (3) @(negedge clk);
        btn_in[1] = 1'b1;
        for (int t = 0; t < 10; t++) begin
            step(1);
            check("bounce_level", btn_level[1], 0);
            check("bounce_pulse", press_pulse[1] | release_pulse[1], 0);
        end

        // hold on channel 2: level rises at k+5, repeats after k+16, k+19, ...
        btn_in[2] = 1'b0;
        for (int t = 0; t <= 16; t++) begin
            step(1);
            check("hold_level", btn_level[2], (t >= 5) ? 1 : 0);
            check("hold_repeat", repeat_pulse[2], (t == 16) ? 1 : 0);
        end
        // release sampled at r=k+17; acceptance lands at k+22, a terminal count
        btn_in[2] = 1'b1;
        for (int s = 0; s < 10; s++) begin
            step(1);
            check("release_pulse", release_pulse[2], (s == 6) ? 1 : 0);
            check("release_repeat", repeat_pulse[2], (s == 2) ? 1 : 0);
        end

        // masked press and release on channel 3
        evt_mask[3] = 1'b1;
        btn_in[3]   = 1'b0;
        saw = 1'b0;
        for (int t = 0; t < 8; t++) begin
            step(1);
            saw = saw | press_pulse[3];
        end
        check("mask_no_press", saw, 0);
        check("mask_level_up", btn_level[3], 1);
        btn_in[3] = 1'b1;
        saw = 1'b0;
        for (int t = 0; t < 8; t++) begin
            step(1);
            saw = saw | release_pulse[3];
        end
        check("mask_no_release", saw, 0);
        check("mask_level_down", btn_level[3], 0);

        // mask cleared mid-hold: terminal at k+16 lost, k+19 emitted
        btn_in[3] = 1'b0;
        for (int t = 0; t <= 16; t++) begin
            step(1);
            check("mask_hold_rep", repeat_pulse[3], 0);
        end
        evt_mask[3] = 1'b0;
        for (int t = 17; t <= 20; t++) begin
            step(1);
            check("unmask_rep", repeat_pulse[3], (t == 19) ? 1 : 0);
        end
        btn_in = '1;
        step(12);

        // reset with channel 2 held and channel 0 mid-debounce (counter 2)
        btn_in[2] = 1'b0;
        step(14);
        check("pre_reset_hold", btn_level[2], 1);
        btn_in[0] = 1'b0;
        step(4);
        rst_n = 1'b0;
        #1;
        check("rst_level", btn_level, 0);
        check("rst_pulses", {press_pulse, release_pulse, repeat_pulse}, 0);
        check("rst_any", any_pressed, 0);
        step(2);
        rst_n = 1'b1;
        for (int s = 0; s < 8; s++) begin
            step(1);
            check("rearm_level", {btn_level[2], btn_level[0]}, (s >= 5) ? 3 : 0);
            check("rearm_press", {press_pulse[2], press_pulse[0]}, (s == 6) ? 3 : 0);
        end
        btn_in = '1;
        step(12);

        // all channels pressed on the same edge
        btn_in = '0;
        for (int s = 0; s < 8; s++) begin
            step(1);
            check("simul_press", press_pulse, (s == 6) ? 4'hf : 4'h0);
        end
        btn_in = '1;
        step(12);

        // randomized activity with occasional resets
        for (int seg = 0; seg < 15; seg++) begin
            rate = rates[$urandom_range(0, 2)];
            for (int c = 0; c < 200; c++) begin
                @(negedge clk);
                for (int ch = 0; ch < N_CH; ch++) begin
                    if ($urandom_range(0, rate - 1) == 0) btn_in[ch] = ~btn_in[ch];
                end
                if ($urandom_range(0, 29) == 0) evt_mask = N_CH'($urandom_range(0, 15));
                if ($urandom_range(0, 999) == 0) begin
                    rst_n = 1'b0;
                    @(negedge clk);
                    rst_n = 1'b1;
                end
            end
        end

        step(2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
